// File: rtl/mem_access_unit.sv
// Byte-wide data memory initiator: turns byte/halfword load/store requests into
// one or two single-byte little-endian memory accesses and returns a one-cycle response.
module mem_access_unit #(
  parameter int ADDR_W   = 7,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic              reqSize,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [15:0]       reqWData,
  output logic              respValid,
  output logic [15:0]       respRData,
  output logic [ADDR_W-1:0] lineNumber,
  output logic [7:0]        memIn,
  output logic              memRead,
  output logic              memWrite,
  input  logic [7:0]        memOut,
  output logic [2:0]        dbgState
);

  // Handshake: a request transfers on a rising edge where reqValid && reqReady;
  // reqReady is registered and only high in IDLE, so req* is sampled exactly once.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC0 = 3'd1;
  localparam logic [2:0] S_ACC1 = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              write_q, write_d;
  logic              size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        cap_q, cap_d;
  logic [15:0]       resp_q, resp_d;

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (ready_q && reqValid) begin
          state_d = S_ACC0;
          write_d = reqWrite;
          size_d  = reqSize;
          addr_d  = reqAddr;
          wdata_d = reqWData;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_ACC0: begin
        if (size_q) begin
          state_d = S_ACC1;
        end else if (write_q) begin
          state_d = S_DONE;
          resp_d  = 16'h0000;
        end else begin
          state_d = S_CAP;
        end
      end
      S_ACC1: begin
        // memOut here carries the low byte read during ACC0.
        if (write_q) begin
          state_d = S_DONE;
          resp_d  = 16'h0000;
        end else begin
          state_d = S_CAP;
          cap_d   = memOut;
        end
      end
      S_CAP: begin
        state_d = S_DONE;
        if (size_q) begin
          resp_d = {memOut, cap_q};
        end else begin
          resp_d = {{8{SIGN_EXT & memOut[7]}}, memOut};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      cap_q   <= 8'h00;
      resp_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      resp_q  <= resp_d;
    end
  end

  // Memory ports decode only registered state; a store drives memWrite, a load memRead.
  always_comb begin
    lineNumber = '0;
    memIn      = 8'h00;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    case (state_q)
      S_ACC0: begin
        lineNumber = addr_q;
        memIn      = wdata_q[7:0];
        memWrite   = write_q;
        memRead    = !write_q;
      end
      S_ACC1: begin
        lineNumber = addr_q + ADDR_W'(1);
        memIn      = wdata_q[15:8];
        memWrite   = write_q;
        memRead    = !write_q;
      end
      default: begin
        lineNumber = '0;
      end
    endcase
  end

  assign reqReady  = ready_q;
  assign respValid = (state_q == S_DONE);
  assign respRData = resp_q;
  assign dbgState  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (zero- and sign-extending) share stimulus,
// each with its own byte memory; responses are checked against a reference byte array.
module tb_mem_access_unit;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic              req_size  = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [15:0]       req_wdata = 16'h0000;

  logic              req_ready0, resp_valid0, mem_read0, mem_write0;
  logic [15:0]       resp_rdata0;
  logic [ADDR_W-1:0] line0;
  logic [7:0]        mem_in0;
  logic [7:0]        mem_out0 = 8'h00;
  logic [2:0]        dbg0;

  logic              req_ready1, resp_valid1, mem_read1, mem_write1;
  logic [15:0]       resp_rdata1;
  logic [ADDR_W-1:0] line1;
  logic [7:0]        mem_in1;
  logic [7:0]        mem_out1 = 8'h00;
  logic [2:0]        dbg1;

  logic [7:0] mem0    [DEPTH] = '{default: 8'h00};
  logic [7:0] mem1    [DEPTH] = '{default: 8'h00};
  logic [7:0] ref_mem [DEPTH] = '{default: 8'h00};

  logic [15:0] exp_q[$];
  logic [15:0] exp_se_q[$];
  int          lat_q[$];
  int          acc_q[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   abort_pending = 1'b0;
  bit   last_hold = 1'b0;
  int   last_acc = 0;
  int   last_lat = 0;
  logic [15:0] hold0 = 16'h0000;
  logic [15:0] hold1 = 16'h0000;

  mem_access_unit #(.ADDR_W(ADDR_W), .SIGN_EXT(1'b0)) dut0 (
    .clk(clk), .rstN(rst_n), .reqValid(req_valid), .reqReady(req_ready0),
    .reqWrite(req_write), .reqSize(req_size), .reqAddr(req_addr), .reqWData(req_wdata),
    .respValid(resp_valid0), .respRData(resp_rdata0), .lineNumber(line0), .memIn(mem_in0),
    .memRead(mem_read0), .memWrite(mem_write0), .memOut(mem_out0), .dbgState(dbg0)
  );

  mem_access_unit #(.ADDR_W(ADDR_W), .SIGN_EXT(1'b1)) dut1 (
    .clk(clk), .rstN(rst_n), .reqValid(req_valid), .reqReady(req_ready1),
    .reqWrite(req_write), .reqSize(req_size), .reqAddr(req_addr), .reqWData(req_wdata),
    .respValid(resp_valid1), .respRData(resp_rdata1), .lineNumber(line1), .memIn(mem_in1),
    .memRead(mem_read1), .memWrite(mem_write1), .memOut(mem_out1), .dbgState(dbg1)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte memories: write on memWrite, registered read on memRead.
  always @(posedge clk) begin
    if (mem_write0) mem0[line0] <= mem_in0;
    if (mem_read0)  mem_out0 <= mem0[line0];
    if (mem_write1) mem1[line1] <= mem_in1;
    if (mem_read1)  mem_out1 <= mem1[line1];
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(mem_read0 && mem_write0));
  assert property (@(posedge clk) disable iff (!rst_n) !(mem_read1 && mem_write1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive_garbage();
    req_write = 1'($urandom_range(0, 1));
    req_size  = 1'($urandom_range(0, 1));
    req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
    req_wdata = 16'($urandom_range(0, 65535));
  endtask

  // Driver: present a request, accept it on the first ready edge, predict its response.
  task automatic issue(input logic w, input logic sz, input logic [ADDR_W-1:0] a,
                       input logic [15:0] d, input bit hold);
    int waited = 0;
    int lat;
    logic [ADDR_W-1:0] a1;
    logic [15:0] e0, e1;
    @(negedge clk);
    req_valid = 1'b1;
    while (!req_ready0) begin
      if (waited >= 40) begin
        check("ready_timeout", 32'(req_ready0), 32'd1);
        req_valid = 1'b0;
        last_hold = 1'b0;
        return;
      end
      drive_garbage();
      @(negedge clk);
      waited++;
    end
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    a1 = a + ADDR_W'(1);
    if (w) begin
      ref_mem[a] = d[7:0];
      if (sz) ref_mem[a1] = d[15:8];
      e0  = 16'h0000;
      e1  = 16'h0000;
      lat = sz ? 3 : 2;
    end else if (sz) begin
      e0  = {ref_mem[a1], ref_mem[a]};
      e1  = e0;
      lat = 4;
    end else begin
      e0  = {8'h00, ref_mem[a]};
      e1  = {{8{ref_mem[a][7]}}, ref_mem[a]};
      lat = 3;
    end
    if (last_hold) check("accept_spacing", 32'(cyc - last_acc), 32'(last_lat + 1));
    exp_q.push_back(e0);
    exp_se_q.push_back(e1);
    lat_q.push_back(lat);
    acc_q.push_back(cyc);
    last_hold = hold;
    last_acc  = cyc;
    last_lat  = lat;
    @(posedge clk);
    #1;
    if (hold) drive_garbage();
    else req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    last_hold = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Scoreboard monitor: sampled a little after each rising edge.
  initial begin
    logic [15:0] e0, e1;
    int lat, acc;
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        hold0 = 16'h0000;
        hold1 = 16'h0000;
      end else begin
        check("rw_overlap0", 32'(mem_read0 & mem_write0), 32'd0);
        check("rw_overlap1", 32'(mem_read1 & mem_write1), 32'd0);
        check("req_ready", 32'(req_ready0), 32'(exp_q.size() == 0 && !abort_pending));
        check("lockstep_state", 32'(dbg1), 32'(dbg0));
        if (resp_valid0) begin
          if (exp_q.size() == 0) begin
            check("spurious_resp", 32'(resp_valid0), 32'd0);
          end else begin
            e0  = exp_q.pop_front();
            e1  = exp_se_q.pop_front();
            lat = lat_q.pop_front();
            acc = acc_q.pop_front();
            check("resp_data", 32'(resp_rdata0), 32'(e0));
            check("resp_data_sext", 32'(resp_rdata1), 32'(e1));
            check("resp_valid_sext", 32'(resp_valid1), 32'd1);
            check("resp_latency", 32'(cyc - acc), 32'(lat));
            hold0 = e0;
            hold1 = e1;
          end
        end else begin
          check("resp_valid_sext_idle", 32'(resp_valid1), 32'd0);
          check("resp_hold", 32'(resp_rdata0), 32'(hold0));
          check("resp_hold_sext", 32'(resp_rdata1), 32'(hold1));
        end
      end
    end
  end

  initial begin
    logic [7:0] saved21;
    logic [ADDR_W-1:0] a;

    // Reset state
    #12;
    check("rst_ready", 32'(req_ready0), 32'd0);
    check("rst_resp_valid", 32'(resp_valid0), 32'd0);
    check("rst_mem_en", 32'({mem_read0, mem_write0, mem_read1, mem_write1}), 32'd0);
    check("rst_line_memin", 32'({line0, mem_in0}), 32'd0);
    check("rst_rdata", 32'(resp_rdata0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_ready_low", 32'(req_ready0), 32'd0);
    @(posedge clk);
    #1;
    check("release_ready_high", 32'(req_ready0), 32'd1);

    // Halfword store/load
    issue(1'b1, 1'b1, 7'h10, 16'hBEEF, 1'b0);
    issue(1'b0, 1'b1, 7'h10, 16'h0000, 1'b0);
    drain();
    check("mem_10", 32'(mem0[7'h10]), 32'h0000_00EF);
    check("mem_11", 32'(mem0[7'h11]), 32'h0000_00BE);

    // Halfword wrapping past the top line
    issue(1'b1, 1'b1, 7'h7F, 16'h1234, 1'b0);
    issue(1'b0, 1'b1, 7'h7F, 16'h0000, 1'b0);
    drain();
    check("mem_7f", 32'(mem0[7'h7F]), 32'h0000_0034);
    check("mem_00", 32'(mem0[7'h00]), 32'h0000_0012);

    // Byte store/load with sign bit set; upper store byte must be ignored
    issue(1'b1, 1'b0, 7'h05, 16'h5A80, 1'b0);
    issue(1'b0, 1'b0, 7'h05, 16'h0000, 1'b0);
    drain();
    check("mem_05", 32'(mem0[7'h05]), 32'h0000_0080);
    check("mem_06_untouched", 32'(mem0[7'h06]), 32'(ref_mem[7'h06]));

    // reqValid held high with changing fields while busy
    issue(1'b1, 1'b1, 7'h30, 16'hC3A5, 1'b1);
    issue(1'b0, 1'b1, 7'h30, 16'h0000, 1'b1);
    issue(1'b0, 1'b0, 7'h31, 16'h0000, 1'b1);
    issue(1'b0, 1'b0, 7'h30, 16'h0000, 1'b0);
    drain();

    // Back-to-back byte stores
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 1'b0, ADDR_W'(7'h40 + i), 16'($urandom_range(0, 65535)), i != 7);
    end
    drain();

    // Reset during the high-byte access of a halfword store
    saved21 = ref_mem[7'h21];
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 1'b1;
    req_addr  = 7'h20;
    req_wdata = 16'hAABB;
    abort_pending = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("acc1_write_active", 32'(mem_write0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_en_drop", 32'({mem_read0, mem_write0, mem_read1, mem_write1}), 32'd0);
    check("abort_ready", 32'(req_ready0), 32'd0);
    check("abort_resp_valid", 32'(resp_valid0 | resp_valid1), 32'd0);
    ref_mem[7'h20] = 8'hBB;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    abort_pending = 1'b0;
    #1;
    check("abort_release_ready_low", 32'(req_ready0), 32'd0);
    @(posedge clk);
    #1;
    check("abort_release_ready_high", 32'(req_ready0), 32'd1);
    check("abort_mem_20", 32'(mem0[7'h20]), 32'h0000_00BB);
    check("abort_mem_21", 32'(mem0[7'h21]), 32'(saved21));
    check("abort_mem1_21", 32'(mem1[7'h21]), 32'(saved21));

    // Randomized traffic, concentrated around the wrap boundary half of the time
    for (int i = 0; i < 150; i++) begin
      bit hold;
      hold = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) a = ADDR_W'(7'h7C + 7'($urandom_range(0, 7)));
      else a = ADDR_W'($urandom_range(0, DEPTH - 1));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
            16'($urandom_range(0, 65535)), hold && (i != 149));
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    for (int i = 0; i < DEPTH; i++) begin
      check("final_mem0", 32'(mem0[i]), 32'(ref_mem[i]));
      check("final_mem1", 32'(mem1[i]), 32'(ref_mem[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
